if_fetch_queue: RTL and testbench

Fetch-side consumer of the PC generator's instruction address stream. Takes the word-addressed `pc` each cycle the PC generator advances and issues it as an instruction-memory read. It holds the returned instructions, tagged with their PC, in an in-order queue for decode. It drives `stall` back to the PC generator, and on a branch redirect it flushes queued entries and silently drops responses still in flight.

---
 rtl/if_fetch_queue_pkg.sv | 22 ++
 rtl/if_fetch_queue_if.sv | 35 +++
 rtl/if_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   fq_entry_t : layout of one queue entry {pc, data, filled} at the default widths
//   DEPTH_DEF / AW_DEF / DW_DEF : default queue depth, address width, instruction width
//   cnt_width(): width of occupancy/credit counters, log2(depth)+1, so the value
//                DEPTH itself (queue full, or DEPTH drops owed) is representable
package if_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] pc;
        logic [DW_DEF-1:0] data;
        logic              filled;
    } fq_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bus bundle between the fetch queue, the PC generator, instruction memory and decode.
//   pc/br/stall                   : PC generator side (stall holds pc)
//   imem_req_* / imem_rsp_*       : instruction-memory read request and in-order response
//   inst_valid/inst_data/inst_pc/inst_ready : head of the queue towards decode
// modport slave  : the fetch queue itself
// modport master : the environment around it (PC generator, memory, decode)
interface if_fetch_queue_if
    import if_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [AW-1:0] pc;
    logic          br;
    logic          stall;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;

    modport slave (
        input  pc, br, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output stall, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport master (
        output pc, br, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  stall, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue.
// Issues the PC generator's current pc as an instruction-memory read whenever a
// credit is available, keeps the returned instructions (tagged with their pc) in
// an in-order circular queue, and presents the head to decode.  A branch redirect
// (br) flushes every queued entry and converts the responses still in flight into
// drop credits so they are discarded on arrival.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : if_fetch_queue_if.slave (pc/br/stall, imem request/response, decode head)
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_queue_if.slave bus
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = cnt_width(DEPTH);
    localparam int PEND_W = CW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    ptr_t head_reg;
    ptr_t tail_reg;
    ptr_t fill_ptr_reg;
    cnt_t count_reg;
    cnt_t drop_cnt_reg;

    logic [DEPTH-1:0] entry_filled;
    logic [AW-1:0]    entry_pc   [DEPTH];
    logic [DW-1:0]    entry_data [DEPTH];

    logic              credit_ok;
    logic              req_fire;
    logic              deq_fire;
    logic              rsp_fill;
    logic              rsp_drop;
    logic [PEND_W-1:0] pending;
    cnt_t              unfilled;

    // Allocated entries plus responses owed for flushed requests bound everything
    // that can still come back from memory, so every response finds a home.
    assign pending   = {1'b0, count_reg} + {1'b0, drop_cnt_reg};
    assign credit_ok = pending < PEND_W'(DEPTH);

    // Outputs are forced quiet while rst is held, independent of the clock.
    assign bus.imem_req_valid = credit_ok & ~bus.br & ~rst;
    assign bus.imem_req_addr  = bus.pc;
    assign bus.stall          = ~(credit_ok & bus.imem_req_ready) | rst;

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;

    assign bus.inst_valid = entry_filled[head_reg] & ~bus.br;
    assign bus.inst_data  = entry_data[head_reg];
    assign bus.inst_pc    = entry_pc[head_reg];

    assign deq_fire = bus.inst_valid & bus.inst_ready;

    assign rsp_drop = bus.imem_rsp_valid & (drop_cnt_reg != '0);
    assign rsp_fill = bus.imem_rsp_valid & (drop_cnt_reg == '0);

    // Requests issued but not yet answered.  tail == fill_ptr is ambiguous: it is
    // DEPTH only when the queue is full and its oldest entry still awaits data.
    always_comb begin
        unfilled = cnt_t'(ptr_t'(tail_reg - fill_ptr_reg));
        if ((tail_reg == fill_ptr_reg) && (count_reg == cnt_t'(DEPTH)) &&
            !entry_filled[fill_ptr_reg]) begin
            unfilled = cnt_t'(DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            fill_ptr_reg <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else if (bus.br) begin
            // A response arriving in the flush cycle settles one of the owed slots.
            head_reg     <= tail_reg;
            fill_ptr_reg <= tail_reg;
            count_reg    <= '0;
            drop_cnt_reg <= drop_cnt_reg + unfilled - cnt_t'(bus.imem_rsp_valid);
        end else begin
            tail_reg     <= tail_reg + ptr_t'(req_fire);
            head_reg     <= head_reg + ptr_t'(deq_fire);
            fill_ptr_reg <= fill_ptr_reg + ptr_t'(rsp_fill);
            count_reg    <= count_reg + cnt_t'(req_fire) - cnt_t'(deq_fire);
            drop_cnt_reg <= drop_cnt_reg - cnt_t'(rsp_drop);
        end
    end

    // Per-entry storage.  Only the filled flag needs reset; pc/data are
    // qualified by it.  Fill never targets the head being dequeued nor the
    // tail being allocated, so the three updates never collide on one entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic          filled_reg;
            logic [AW-1:0] pc_reg;
            logic [DW-1:0] data_reg;
            logic          alloc_hit;
            logic          fill_hit;
            logic          deq_hit;

            assign alloc_hit = req_fire & (tail_reg == ptr_t'(gi));
            assign fill_hit  = rsp_fill & (fill_ptr_reg == ptr_t'(gi));
            assign deq_hit   = deq_fire & (head_reg == ptr_t'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filled_reg <= 1'b0;
                end else if (bus.br) begin
                    filled_reg <= 1'b0;
                end else if (fill_hit) begin
                    filled_reg <= 1'b1;
                end else if (alloc_hit || deq_hit) begin
                    filled_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (alloc_hit) begin
                    pc_reg <= bus.pc;
                end
                if (fill_hit) begin
                    data_reg <= bus.imem_rsp_data;
                end
            end

            assign entry_filled[gi] = filled_reg;
            assign entry_pc[gi]     = pc_reg;
            assign entry_data[gi]   = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic clk;
    logic rst;

    if_fetch_queue_if #(.AW(32), .DW(32)) bus ();

    if_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] log_q[$];
    int          cyc;
    int          fire_cnt;
    int          lat;
    logic [31:0] br_target;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PC generator, fixed-latency in-order memory and scoreboard producer.
    always @(posedge clk or posedge rst) begin
        int now;
        if (rst) begin
            cyc                <= 0;
            fire_cnt           <= 0;
            bus.pc             <= '0;
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            mq.delete();
            exp_q.delete();
        end else begin
            now = cyc + 1;
            cyc <= now;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_req_addr, due: now - 1 + lat});
                exp_q.push_back(bus.imem_req_addr);
                fire_cnt <= fire_cnt + 1;
            end
            if (bus.br) begin
                exp_q.delete();
                bus.pc <= br_target;
            end else if (!bus.stall) begin
                bus.pc <= bus.pc + 32'd1;
            end
            if (mq.size() > 0 && mq[0].due <= now) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= mdata(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (bus.imem_req_valid) begin
                chk("req_addr", bus.imem_req_addr, bus.pc);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                $display("inst pc=%0d data=0x%08h", bus.inst_pc, bus.inst_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: got pc %0d expected no instruction", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", bus.inst_pc, e);
                    chk("inst_data", bus.inst_data, mdata(e));
                end
                log_q.push_back(bus.inst_pc);
            end
        end
    end

    task automatic check_seq(input string name, input int base, input int expect_n);
        chk({name, "_count"}, log_q.size(), expect_n);
        chk({name, "_pending"}, exp_q.size(), 0);
        for (int i = 0; i < log_q.size(); i++) begin
            chk({name, "_pc"}, log_q[i], base + i);
        end
    endtask

    task automatic br_pulse(input logic [31:0] target);
        bus.br    = 1'b1;
        br_target = target;
        step();
        bus.br    = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        int f0;
        logic [31:0] p0;
        logic [31:0] held;
        bit found;

        rst                = 1'b1;
        bus.br             = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        lat                = 1;
        br_target          = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.stall, 1);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);

        // Test 1: zero-wait memory, decode always ready
        rst = 1'b0;
        #1;
        chk("t1_first_req_valid", bus.imem_req_valid, 1);
        chk("t1_first_req_addr", bus.imem_req_addr, 0);
        chk("t1_first_stall", bus.stall, 0);
        step();
        chk("t1_no_bypass", bus.inst_valid, 0);
        step();
        chk("t1_inst_valid_c2", bus.inst_valid, 1);
        chk("t1_inst_pc_c2", bus.inst_pc, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_stall", bus.stall, 0);
        end
        bus.imem_req_ready = 1'b0;
        repeat (6) step();
        check_seq("t1", 0, fire_cnt);

        // Test 2: decode blocked fills credits, one-cycle release
        log_q.delete();
        mark = fire_cnt;
        p0 = bus.pc;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (4) step();
        chk("t2_full_stall", bus.stall, 1);
        chk("t2_full_req_valid", bus.imem_req_valid, 0);
        chk("t2_fires4", fire_cnt - mark, 4);
        repeat (3) step();
        chk("t2_hold_fires", fire_cnt - mark, 4);
        chk("t2_hold_pc", bus.pc, p0 + 4);
        bus.inst_ready = 1'b1;
        #1;
        chk("t2_deq_cycle_req_valid", bus.imem_req_valid, 0);
        step();
        bus.inst_ready = 1'b0;
        #1;
        chk("t2_next_req_valid", bus.imem_req_valid, 1);
        chk("t2_next_req_addr", bus.imem_req_addr, p0 + 4);
        step();
        chk("t2_refull_req_valid", bus.imem_req_valid, 0);
        chk("t2_fires5", fire_cnt - mark, 5);
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b1;
        repeat (6) step();
        check_seq("t2", int'(p0), 5);

        // Test 3: 3-cycle latency, flush with 10,11,12 outstanding
        log_q.delete();
        br_pulse(32'd10);
        lat                = 3;
        bus.imem_req_ready = 1'b1;
        mark = fire_cnt;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bus.pc == 32'd13) found = 1'b1;
        end
        chk("t3_reach_pc13", found, 1);
        bus.br    = 1'b1;
        br_target = 32'd40;
        #1;
        chk("t3_br_req_valid", bus.imem_req_valid, 0);
        chk("t3_br_inst_valid", bus.inst_valid, 0);
        step();
        bus.br = 1'b0;
        repeat (6) step();
        bus.imem_req_ready = 1'b0;
        repeat (8) step();
        check_seq("t3", 40, fire_cnt - mark - 3);

        // Test 4: br together with response for pc 5 and head pc 4
        log_q.delete();
        br_pulse(32'd0);
        lat                = 2;
        bus.imem_req_ready = 1'b1;
        mark = fire_cnt;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.inst_valid && bus.inst_pc == 32'd4 &&
                bus.imem_rsp_valid && bus.imem_rsp_data == mdata(32'd5)) found = 1'b1;
        end
        chk("t4_reach_collision", found, 1);
        bus.br    = 1'b1;
        br_target = 32'd100;
        #1;
        chk("t4_br_inst_valid", bus.inst_valid, 0);
        chk("t4_br_req_valid", bus.imem_req_valid, 0);
        step();
        bus.br = 1'b0;
        repeat (6) step();
        bus.imem_req_ready = 1'b0;
        repeat (6) step();
        chk("t4_count", log_q.size(), fire_cnt - mark - 3);
        chk("t4_pending", exp_q.size(), 0);
        for (int i = 0; i < log_q.size(); i++) begin
            chk("t4_pc", log_q[i], (i < 4) ? i : 96 + i);
        end

        // Test 5: memory not ready for 5 cycles
        log_q.delete();
        br_pulse(32'd200);
        lat                = 1;
        bus.imem_req_ready = 1'b1;
        mark = fire_cnt;
        repeat (4) step();
        bus.imem_req_ready = 1'b0;
        held = bus.pc;
        f0 = fire_cnt;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_stall", bus.stall, 1);
            step();
            chk("t5_pc_hold", bus.pc, held);
        end
        chk("t5_no_alloc", fire_cnt, f0);
        bus.imem_req_ready = 1'b1;
        repeat (4) step();
        bus.imem_req_ready = 1'b0;
        repeat (5) step();
        check_seq("t5", 200, fire_cnt - mark);

        // Test 6: reset with two entries filled and one in flight
        bus.inst_ready     = 1'b0;
        lat                = 2;
        bus.imem_req_ready = 1'b1;
        repeat (3) step();
        bus.imem_req_ready = 1'b0;
        step();
        chk("t6_pre_inst_valid", bus.inst_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_inst_valid", bus.inst_valid, 0);
        chk("t6_rst_req_valid", bus.imem_req_valid, 0);
        chk("t6_rst_stall", bus.stall, 1);
        log_q.delete();
        step();
        lat                = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        rst                = 1'b0;
        repeat (6) step();
        bus.imem_req_ready = 1'b0;
        repeat (4) step();
        check_seq("t6", 0, fire_cnt);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
